// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand/result valid-ready channels of the serial adder
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic in_valid, in_ready, cin, out_valid, out_ready, cout, overflow;
  logic [WIDTH-1:0] a, b, sum;
  modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, overflow);
  modport slave (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, overflow);
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder time-sharing one full adder, LSB first, WIDTH cycles per add
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder_ctrl #(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic rst_n,
  serial_adder_ctrl_if.slave bus,
  output logic busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, r, sum_q;
  logic [CW-1:0] cnt;
  logic c, fa_s, fa_co, cout_q, ovf_q;
  full_adder u_fa (.x(sa[0]), .y(sb[0]), .ci(c), .s(fa_s), .co(fa_co));
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign busy = state != IDLE;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
  assign bus.overflow = ovf_q;
  // on the last bit, c still holds the carry into the MSB
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      r <= '0;
      sum_q <= '0;
      cnt <= '0;
      c <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.in_valid) begin
          sa <= bus.a;
          sb <= bus.b;
          c <= bus.cin;
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          r <= {fa_s, r[WIDTH-1:1]};
          sa <= sa >> 1;
          sb <= sb >> 1;
          c <= fa_co;
          cnt <= cnt == LAST ? cnt : cnt + 1'b1;
          if (cnt == LAST) begin
            sum_q <= {fa_s, r[WIDTH-1:1]};
            cout_q <= fa_co;
            ovf_q <= c ^ fa_co;
            state <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for WIDTH=8 directed tests and WIDTH=2/16 random compares
module tb_serial_adder_ctrl;
  typedef struct packed {logic [63:0] s; logic co; logic of;} exp_t;
  logic clk = 0, rst_n = 0;
  logic [63:0] a64 = 0, b64 = 0;
  logic cin_t = 0, iv = 0, ordy = 0;
  int sel = 8, checks = 0, errors = 0, cyc = 0;
  exp_t q[$];
  logic b2, b8, b16, ir, ov, co, of, bsy;
  logic [63:0] sm;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl_if #(.WIDTH(2)) i2 ();
  serial_adder_ctrl_if #(.WIDTH(8)) i8 ();
  serial_adder_ctrl_if #(.WIDTH(16)) i16 ();
  serial_adder_ctrl #(.WIDTH(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2), .busy(b2));
  serial_adder_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8), .busy(b8));
  serial_adder_ctrl #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16), .busy(b16));

  assign i2.a = a64[1:0];
  assign i2.b = b64[1:0];
  assign i2.cin = cin_t;
  assign i2.in_valid = iv && sel == 2;
  assign i2.out_ready = ordy && sel == 2;
  assign i8.a = a64[7:0];
  assign i8.b = b64[7:0];
  assign i8.cin = cin_t;
  assign i8.in_valid = iv && sel == 8;
  assign i8.out_ready = ordy && sel == 8;
  assign i16.a = a64[15:0];
  assign i16.b = b64[15:0];
  assign i16.cin = cin_t;
  assign i16.in_valid = iv && sel == 16;
  assign i16.out_ready = ordy && sel == 16;

  always_comb begin
    ir = sel == 2 ? i2.in_ready : sel == 16 ? i16.in_ready : i8.in_ready;
    ov = sel == 2 ? i2.out_valid : sel == 16 ? i16.out_valid : i8.out_valid;
    co = sel == 2 ? i2.cout : sel == 16 ? i16.cout : i8.cout;
    of = sel == 2 ? i2.overflow : sel == 16 ? i16.overflow : i8.overflow;
    bsy = sel == 2 ? b2 : sel == 16 ? b16 : b8;
    sm = sel == 2 ? 64'(i2.sum) : sel == 16 ? 64'(i16.sum) : 64'(i8.sum);
  end

  function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y, input logic c);
    logic [64:0] f;
    exp_t e;
    f = {1'b0, x} + {1'b0, y} + {64'b0, c};
    e.s = f[63:0] & ((64'd1 << w) - 64'd1);
    e.co = f[w];
    e.of = (x[w-1] == y[w-1]) && (f[w-1] != x[w-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ov(output int n);
    n = 0;
    while (!ov && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (ov) else begin
      errors++;
      $error("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic wait_ir();
    int n = 0;
    while (!ir && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (ir) else begin
      errors++;
      $error("FAIL in_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic c);
    a64 = x;
    b64 = y;
    cin_t = c;
    iv = 1;
    wait_ir();
    @(negedge clk);
    iv = 0;
    q.push_back(model(sel, x, y, c));
  endtask

  task automatic compare_front();
    exp_t e;
    e = '0;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: got empty queue expected entry");
    end else e = q.pop_front();
    chk("sum", sm, e.s);
    chk("cout", 64'(co), 64'(e.co));
    chk("overflow", 64'(of), 64'(e.of));
  endtask

  task automatic recv(input int stall, input bit lat);
    int n;
    logic [63:0] s0;
    ordy = 0;
    wait_ov(n);
    if (lat) chk("latency", 64'(n), 64'(sel));
    s0 = sm;
    compare_front();
    repeat (stall) begin
      @(negedge clk);
      chk("hold_sum", sm, s0);
    end
    ordy = 1;
    @(negedge clk);
    ordy = 0;
    chk("out_valid_drop", 64'(ov), 64'd0);
  endtask

  initial begin
    int t, tp, n;
    logic [63:0] mk, s0;
    logic c0, o0;
    logic [63:0] pa [4] = '{64'h01, 64'h80, 64'hFF, 64'h33};
    logic [63:0] pb [4] = '{64'h02, 64'h80, 64'hFF, 64'h44};
    logic pc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(ir), 64'd1);
    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_busy", 64'(bsy), 64'd0);
    chk("rst_sum", sm, 64'd0);
    chk("rst_cout", 64'(co), 64'd0);
    chk("rst_overflow", 64'(of), 64'd0);
    rst_n = 1;
    @(negedge clk);
    send(64'h5A, 64'h3C, 1'b0);
    chk("busy_run", 64'(bsy), 64'd1);
    chk("in_ready_run", 64'(ir), 64'd0);
    recv(0, 1);
    send(64'hFF, 64'h01, 1'b0);
    recv(1, 1);
    send(64'h7F, 64'h00, 1'b1);
    recv(0, 1);
    // backpressure: a different pair waits on in_valid while the result is held
    send(64'h40, 64'h40, 1'b0);
    ordy = 0;
    wait_ov(n);
    s0 = sm;
    c0 = co;
    o0 = of;
    compare_front();
    a64 = 64'h11;
    b64 = 64'h22;
    cin_t = 0;
    iv = 1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_sum", sm, s0);
      chk("bp_cout", 64'(co), 64'(c0));
      chk("bp_ovf", 64'(of), 64'(o0));
      chk("bp_in_ready", 64'(ir), 64'd0);
      chk("bp_out_valid", 64'(ov), 64'd1);
    end
    ordy = 1;
    @(negedge clk);
    ordy = 0;
    chk("bp_hs_out_valid", 64'(ov), 64'd0);
    chk("bp_hs_in_ready", 64'(ir), 64'd1);
    @(negedge clk);
    iv = 0;
    chk("bp_accept_busy", 64'(bsy), 64'd1);
    q.push_back(model(8, 64'h11, 64'h22, 1'b0));
    recv(0, 1);
    // back-to-back with in_valid and out_ready held high
    ordy = 1;
    iv = 1;
    tp = 0;
    for (int k = 0; k < 4; k++) begin
      a64 = pa[k];
      b64 = pb[k];
      cin_t = pc[k];
      wait_ir();
      t = cyc;
      if (k > 0) chk("b2b_gap", 64'(t - tp), 64'd10);
      tp = t;
      @(negedge clk);
      q.push_back(model(8, pa[k], pb[k], pc[k]));
      wait_ov(n);
      compare_front();
    end
    iv = 0;
    @(negedge clk);
    ordy = 0;
    // reset in the third RUN cycle aborts the add
    a64 = 64'h12;
    b64 = 64'h34;
    cin_t = 1;
    iv = 1;
    wait_ir();
    @(negedge clk);
    iv = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_out_valid", 64'(ov), 64'd0);
    chk("abort_in_ready", 64'(ir), 64'd1);
    chk("abort_busy", 64'(bsy), 64'd0);
    chk("abort_sum", sm, 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    send(64'h01, 64'h01, 1'b0);
    recv(0, 1);
    for (int k = 0; k < 2; k++) begin
      sel = k == 0 ? 2 : 16;
      mk = (64'd1 << sel) - 64'd1;
      repeat (1000) begin
        send({32'b0, $urandom} & mk, {32'b0, $urandom} & mk, 1'($urandom_range(0, 1)));
        recv($urandom_range(0, 3), 1);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
